fb_rect_fill: RTL and testbench

Rectangle fill engine upstream of the framebuffer that the VGA output stage reads. It accepts one fill command at a time (two corners plus a 3-bit RGB colour) over a valid/ready handshake. It normalises and clips the rectangle to the visible area, then emits one framebuffer write per pixel in raster order. Write addresses use the framebuffer's packed `{x[9:0], y[9:0]}` format, so the VGA stage's `pixel_addr` and this block's `wr_addr` index the same memory.

---
 rtl/fb_rect_fill_if.sv | 28 ++
 rtl/fb_rect_fill.sv | 169 ++++++++++++++++
 tb/tb_fb_rect_fill.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fb_rect_fill_if.sv
// Command and framebuffer-write bundle for the rectangle fill engine.
// The host side drives commands and the stall; the engine (slave) drives writes and status.
interface fb_rect_fill_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x0;
    logic [9:0]  cmd_y0;
    logic [9:0]  cmd_x1;
    logic [9:0]  cmd_y1;
    logic [2:0]  cmd_rgb;
    logic        wr_en;
    logic [19:0] wr_addr;
    logic [2:0]  wr_data;
    logic        wr_stall;
    logic        busy;
    logic        done;
    logic [18:0] pix_cnt;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_rgb, wr_stall,
        input  cmd_ready, wr_en, wr_addr, wr_data, busy, done, pix_cnt
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_rgb, wr_stall,
        output cmd_ready, wr_en, wr_addr, wr_data, busy, done, pix_cnt
    );
endinterface

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: normalises and clips one command, then emits one
// framebuffer write per pixel in raster order using packed {x, y} addresses.
module fb_rect_fill #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input logic           sysclk,
    input logic           rst_n,
    fb_rect_fill_if.slave bus
);

    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  cx0_q, cx0_d, cy0_q, cy0_d, cx1_q, cx1_d, cy1_q, cy1_d;
    logic [2:0]  rgb_q, rgb_d;
    logic [9:0]  xl_q, xl_d, xh_q, xh_d, yh_q, yh_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        wr_en_q, wr_en_d;
    logic [19:0] wr_addr_q, wr_addr_d;
    logic [2:0]  wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [18:0] pix_cnt_q, pix_cnt_d;

    logic [9:0]  xl_c, xh_c, yl_c, yh_c;
    logic        last_px;

    assign xl_c    = (cx0_q < cx1_q) ? cx0_q : cx1_q;
    assign xh_c    = (cx0_q < cx1_q) ? cx1_q : cx0_q;
    assign yl_c    = (cy0_q < cy1_q) ? cy0_q : cy1_q;
    assign yh_c    = (cy0_q < cy1_q) ? cy1_q : cy0_q;
    assign last_px = (x_q == xh_q) && (y_q == yh_q);

    always_comb begin
        state_d     = state_q;
        cx0_d       = cx0_q;
        cy0_d       = cy0_q;
        cx1_d       = cx1_q;
        cy1_d       = cy1_q;
        rgb_d       = rgb_q;
        xl_d        = xl_q;
        xh_d        = xh_q;
        yh_d        = yh_q;
        x_d         = x_q;
        y_d         = y_q;
        cmd_ready_d = cmd_ready_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pix_cnt_d   = pix_cnt_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    cx0_d       = bus.cmd_x0;
                    cy0_d       = bus.cmd_y0;
                    cx1_d       = bus.cmd_x1;
                    cy1_d       = bus.cmd_y1;
                    rgb_d       = bus.cmd_rgb;
                    pix_cnt_d   = '0;
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = CLIP;
                end
            end
            CLIP: begin
                // A rectangle whose low corner is off-screen has no visible pixels.
                if (xl_c > X_MAX || yl_c > Y_MAX) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    xl_d      = xl_c;
                    xh_d      = (xh_c > X_MAX) ? X_MAX : xh_c;
                    yh_d      = (yh_c > Y_MAX) ? Y_MAX : yh_c;
                    x_d       = xl_c;
                    y_d       = yl_c;
                    wr_en_d   = 1'b1;
                    wr_addr_d = {xl_c, yl_c};
                    wr_data_d = rgb_q;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (!bus.wr_stall) begin
                    pix_cnt_d = pix_cnt_q + 19'd1;
                    if (last_px) begin
                        wr_en_d = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        if (x_q < xh_q) begin
                            x_d = x_q + 10'd1;
                        end else begin
                            x_d = xl_q;
                            y_d = y_q + 10'd1;
                        end
                        wr_addr_d = {x_d, y_d};
                    end
                end
            end
            DONE: begin
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cx0_q       <= '0;
            cy0_q       <= '0;
            cx1_q       <= '0;
            cy1_q       <= '0;
            rgb_q       <= '0;
            xl_q        <= '0;
            xh_q        <= '0;
            yh_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            cmd_ready_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cx0_q       <= cx0_d;
            cy0_q       <= cy0_d;
            cx1_q       <= cx1_d;
            cy1_q       <= cy1_d;
            rgb_q       <= rgb_d;
            xl_q        <= xl_d;
            xh_q        <= xh_d;
            yh_q        <= yh_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cmd_ready_q <= cmd_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pix_cnt_q   <= pix_cnt_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pix_cnt   = pix_cnt_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: directed and random fill commands compared
// against a pixel-list model built from nested loops over the clipped rectangle.
module tb_fb_rect_fill;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;

    always #5 sysclk = ~sysclk;

    fb_rect_fill_if bus ();

    fb_rect_fill #(
        .H_ACTIVE(640),
        .V_ACTIVE(480)
    ) dut (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [22:0] exp_q[$];
    logic [22:0] obs_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected write list: every visible pixel of the normalised rectangle, row by row.
    function automatic void buildModel(input int x0, input int y0, input int x1, input int y1,
                                       input logic [2:0] rgb);
        int xl, xh, yl, yh;
        logic [9:0] px, py;
        exp_q.delete();
        xl = (x0 < x1) ? x0 : x1;
        xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1;
        yh = (y0 < y1) ? y1 : y0;
        if (xl >= 640 || yl >= 480) return;
        if (xh > 639) xh = 639;
        if (yh > 479) yh = 479;
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                px = x[9:0];
                py = y[9:0];
                exp_q.push_back({px, py, rgb});
            end
        end
    endfunction

    function automatic logic stallFor(input int mode, input int k);
        if (mode == 1) return ($urandom_range(0, 2) == 0);
        if (mode == 2) return (k >= 1 && k <= 3);
        return 1'b0;
    endfunction

    // mode 0: no stall, 1: random stall, 2: stall cycles 1..3 after accept.
    task automatic applyStimulus(input string tag, input int x0, input int y0, input int x1,
                                 input int y1, input logic [2:0] rgb, input int mode,
                                 input int noise);
        int k, done_k, wr_cycles, first_hold, p, guard;
        logic got_done;
        buildModel(x0, y0, x1, y1, rgb);
        p = exp_q.size();
        obs_q.delete();
        guard = 0;
        @(negedge sysclk);
        while (!bus.cmd_ready && guard < 20) begin
            @(negedge sysclk);
            guard++;
        end
        checkOutput({tag, " ready_before"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_x0    = x0[9:0];
        bus.cmd_y0    = y0[9:0];
        bus.cmd_x1    = x1[9:0];
        bus.cmd_y1    = y1[9:0];
        bus.cmd_rgb   = rgb;
        @(posedge sysclk);
        #1;
        bus.cmd_valid = 1'b0;
        k = 0;
        bus.wr_stall = stallFor(mode, k);
        got_done   = 1'b0;
        done_k     = -1;
        wr_cycles  = 0;
        first_hold = 0;
        for (int g = 0; g < p * 4 + 50; g++) begin
            @(negedge sysclk);
            if (k == 0) begin
                checkOutput({tag, " busy_clip"}, 32'(bus.busy), 32'd1);
                checkOutput({tag, " ready_clip"}, 32'(bus.cmd_ready), 32'd0);
            end
            if (bus.wr_en) begin
                wr_cycles++;
                if (p > 0 && {bus.wr_addr, bus.wr_data} == exp_q[0]) first_hold++;
                if (!bus.wr_stall) obs_q.push_back({bus.wr_addr, bus.wr_data});
            end
            if (bus.done) begin
                got_done = 1'b1;
                done_k   = k;
                break;
            end
            @(posedge sysclk);
            #1;
            k++;
            bus.wr_stall = stallFor(mode, k);
            if (noise != 0) begin
                bus.cmd_valid = (k == 1 || k == 2);
                bus.cmd_x0    = 10'($urandom_range(0, 300));
                bus.cmd_y0    = 10'($urandom_range(0, 300));
            end
        end
        bus.wr_stall  = 1'b0;
        bus.cmd_valid = 1'b0;
        checkOutput({tag, " done_seen"}, 32'(got_done), 32'd1);
        checkOutput({tag, " pix_cnt"}, 32'(bus.pix_cnt), 32'(p));
        checkOutput({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " write_count"}, 32'(obs_q.size()), 32'(p));
        for (int i = 0; i < p && i < obs_q.size(); i++) begin
            checkOutput($sformatf("%s write%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        end
        if (mode == 0 && p > 0) begin
            checkOutput({tag, " done_latency"}, 32'(done_k), 32'(p + 1));
            checkOutput({tag, " wr_en_cycles"}, 32'(wr_cycles), 32'(p));
            checkOutput({tag, " first_hold"}, 32'(first_hold), 32'd1);
        end
        if (mode == 2) begin
            checkOutput({tag, " wr_en_cycles"}, 32'(wr_cycles), 32'(p + 3));
            checkOutput({tag, " first_hold"}, 32'(first_hold), 32'd4);
        end
        @(negedge sysclk);
        checkOutput({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " ready_after"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        int rx0, ry0, rx1, ry1, wr_seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0    = '0;
        bus.cmd_y0    = '0;
        bus.cmd_x1    = '0;
        bus.cmd_y1    = '0;
        bus.cmd_rgb   = '0;
        bus.wr_stall  = 1'b0;

        // Reset state and cmd_ready rising on the first edge after release.
        #2;
        checkOutput("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("reset wr_en", 32'(bus.wr_en), 32'd0);
        checkOutput("reset wr_addr", 32'(bus.wr_addr), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset pix_cnt", 32'(bus.pix_cnt), 32'd0);
        #10 rst_n = 1'b1;
        #1;
        checkOutput("release ready_low", 32'(bus.cmd_ready), 32'd0);
        @(posedge sysclk);
        #1;
        checkOutput("release ready_high", 32'(bus.cmd_ready), 32'd1);

        $display("[TB] directed commands");
        applyStimulus("single", 5, 7, 5, 7, 3'b101, 0, 0);
        applyStimulus("swapped", 12, 4, 10, 3, 3'd2, 0, 1);
        applyStimulus("clip", 630, 470, 700, 900, 3'd6, 0, 0);
        checkOutput("clip last_addr", 32'(obs_q[$]), 32'({10'd639, 10'd479, 3'd6}));
        applyStimulus("offscreen", 640, 0, 700, 10, 3'd1, 0, 0);
        applyStimulus("after_empty", 0, 0, 1, 0, 3'd3, 0, 0);
        applyStimulus("stall", 20, 30, 21, 30, 3'd4, 2, 0);

        $display("[TB] random commands");
        for (int n = 0; n < 12; n++) begin
            rx0 = $urandom_range(0, 660);
            ry0 = $urandom_range(0, 500);
            rx1 = rx0 + $urandom_range(0, 8) - 4;
            ry1 = ry0 + $urandom_range(0, 8) - 4;
            if (rx1 < 0) rx1 = 0;
            if (ry1 < 0) ry1 = 0;
            applyStimulus($sformatf("rand%0d", n), rx0, ry0, rx1, ry1, 3'($urandom),
                          int'($urandom_range(0, 1)), 0);
        end

        // Reset in the middle of a 100-pixel fill.
        $display("[TB] reset during fill");
        @(negedge sysclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_x0    = 10'd100;
        bus.cmd_y0    = 10'd100;
        bus.cmd_x1    = 10'd109;
        bus.cmd_y1    = 10'd109;
        bus.cmd_rgb   = 3'd7;
        @(posedge sysclk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (30) @(posedge sysclk);
        #2;
        checkOutput("midfill wr_en_before", 32'(bus.wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset wr_en", 32'(bus.wr_en), 32'd0);
        checkOutput("midreset wr_addr", 32'(bus.wr_addr), 32'd0);
        checkOutput("midreset wr_data", 32'(bus.wr_data), 32'd0);
        checkOutput("midreset busy", 32'(bus.busy), 32'd0);
        checkOutput("midreset pix_cnt", 32'(bus.pix_cnt), 32'd0);
        checkOutput("midreset cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge sysclk);
        @(negedge sysclk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset ready_low", 32'(bus.cmd_ready), 32'd0);
        @(posedge sysclk);
        #1;
        checkOutput("post_reset ready_high", 32'(bus.cmd_ready), 32'd1);
        wr_seen = 0;
        repeat (20) begin
            @(negedge sysclk);
            if (bus.wr_en || bus.busy) wr_seen++;
        end
        checkOutput("post_reset no_write", 32'(wr_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
